// File: rtl/capture_channel_demapper_pkg.sv
// Shared constants, types and lane-mapping helper for the capture packing/unpacking path.
package capture_pkg;

  localparam int LANES  = 32;
  localparam int LANE_W = 8;
  localparam int WORD_W = 256;
  localparam logic [2:0] MAX_MODE = 3'd5;

  typedef logic [LANES-1:0][LANE_W-1:0] lane_states_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } demap_state_t;

  // Maps the top 8*2^mode bits of 'bits' onto lanes 0..2^mode-1; other lanes are 0.
  function automatic lane_states_t chunk_to_lanes(input logic [2:0] mode,
                                                  input logic [WORD_W-1:0] bits);
    lane_states_t lanes;
    logic [WORD_W-1:0] s;
    int cw;
    lanes = '0;
    s = '0;
    cw = 0;
    if (mode <= MAX_MODE) begin
      cw = LANE_W << mode;
      s = bits >> (WORD_W - cw);
      for (int k = 0; k < LANES; k++) begin
        if (k < (1 << mode)) begin
          lanes[k] = s[LANE_W*k +: LANE_W];
        end
      end
    end
    return lanes;
  endfunction

endpackage

// File: rtl/capture_channel_demapper.sv
// Unpacks 256-bit capture words, oldest chunk first, into per-cycle 32x8 lane-state vectors.
module capture_channel_demapper
  import capture_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   channels,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_states,
  output logic         out_last,
  output logic         err_mode
);

  demap_state_t      state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [2:0]        mode_q, mode_d;
  logic              err_q, err_d;
  lane_states_t      states_q, states_d;
  logic              last_q, last_d;
  logic              accept;
  int                cw;

  // The only input-to-output comb path: a word may enter as the final chunk leaves.
  assign in_ready = (state_q == ST_IDLE) || (out_ready && (cnt_q == 5'd0));
  assign accept   = in_valid && in_ready;
  assign cw       = LANE_W << mode_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    err_d   = err_q;

    if (state_q == ST_EMIT && out_ready && cnt_q != 5'd0) begin
      hold_d = hold_q << cw;
      cnt_d  = cnt_q - 5'd1;
    end else if (state_q == ST_IDLE || out_ready) begin
      // Either idle, or the final chunk is being consumed this cycle.
      state_d = ST_IDLE;
      if (accept) begin
        if (channels <= MAX_MODE) begin
          hold_d  = in_data;
          mode_d  = channels;
          cnt_d   = 5'((LANES >> channels) - 1);
          state_d = ST_EMIT;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    states_d = (state_d == ST_EMIT) ? chunk_to_lanes(mode_d, hold_d) : '0;
    last_d   = (state_d == ST_EMIT) && (cnt_d == 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
      states_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      states_q <= states_d;
      last_q   <= last_d;
    end
  end

  assign out_valid  = (state_q == ST_EMIT);
  assign out_states = states_q;
  assign out_last   = last_q;
  assign err_mode   = err_q;

endmodule

// File: tb/tb_capture_channel_demapper.sv
// Directed self-checking bench for capture_channel_demapper.
module tb_capture_channel_demapper;

  logic         clk;
  logic         rst;
  logic [2:0]   channels;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_states;
  logic         out_last;
  logic         err_mode;

  int errors;
  int checks;

  capture_channel_demapper dut (
    .clk        (clk),
    .rst        (rst),
    .channels   (channels),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_states (out_states),
    .out_last   (out_last),
    .err_mode   (err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (out_states !== 256'd0) begin errors++; $display("FAIL reset_out_states got=%h exp=0", out_states); end
    checks++; if (err_mode !== 1'b0) begin errors++; $display("FAIL reset_err_mode got=%b exp=0", err_mode); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    $display("reset: out_valid=%b err_mode=%b", out_valid, err_mode);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mode5_back_to_back;
    logic [255:0] words [3];
    words[0] = {8{32'hA5A5_0001}};
    words[1] = {8{32'h1234_5678}};
    words[2] = {4{64'hFEDC_BA98_7654_3210}};
    @(negedge clk);
    channels = 3'd5; out_ready = 1'b1; in_valid = 1'b1; in_data = words[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m5_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_states !== words[i]) begin errors++; $display("FAIL m5_states[%0d] got=%h exp=%h", i, out_states, words[i]); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL m5_last[%0d] got=%b exp=1", i, out_last); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL m5_in_ready[%0d] got=%b exp=1", i, in_ready); end
      $display("mode5 word %0d: states=%h last=%b", i, out_states, out_last);
      if (i < 2) in_data = words[i+1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m5_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mode0;
    logic [255:0] w;
    logic [255:0] exp;
    for (int j = 0; j < 32; j++) w[255-8*j -: 8] = 8'(j + 1);
    @(negedge clk);
    channels = 3'd0; out_ready = 1'b1; in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL m0_in_ready_midword got=%b exp=0", in_ready); end
    for (int c = 0; c < 32; c++) begin
      exp = {248'd0, 8'(c + 1)};
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m0_valid[%0d] got=%b exp=1", c, out_valid); end
      checks++; if (out_states !== exp) begin errors++; $display("FAIL m0_states[%0d] got=%h exp=%h", c, out_states, exp); end
      checks++; if (out_last !== (c == 31)) begin errors++; $display("FAIL m0_last[%0d] got=%b exp=%b", c, out_last, (c == 31)); end
      $display("mode0 chunk %0d: lane0=%h last=%b", c, out_states[7:0], out_last);
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mode3;
    logic [63:0] parts [4];
    logic [255:0] exp;
    parts[0] = 64'h8877665544332211;
    parts[1] = 64'h0F0E0D0C0B0A0908;
    parts[2] = 64'hFFEEDDCCBBAA9988;
    parts[3] = 64'h1234567890ABCDEF;
    @(negedge clk);
    channels = 3'd3; out_ready = 1'b1; in_valid = 1'b1;
    in_data = {parts[0], parts[1], parts[2], parts[3]};
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp = {192'd0, parts[c]};
      checks++; if (out_states !== exp) begin errors++; $display("FAIL m3_states[%0d] got=%h exp=%h", c, out_states, exp); end
      checks++; if (out_last !== (c == 3)) begin errors++; $display("FAIL m3_last[%0d] got=%b exp=%b", c, out_last, (c == 3)); end
      $display("mode3 chunk %0d: lanes7..0=%h last=%b", c, out_states[63:0], out_last);
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m3_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall;
    logic [255:0] w;
    logic [255:0] exp;
    int idx;
    logic took;
    w = 256'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF_1020_3040_5060_7080_90A0_B0C0_D0E0_F001;
    idx = 0;
    @(negedge clk);
    channels = 3'd2; out_ready = 1'b0; in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0; channels = 3'd4;
    for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
      exp = {224'd0, w[255-32*idx -: 32]};
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", idx, out_valid); end
      checks++; if (out_states !== exp) begin errors++; $display("FAIL stall_states[%0d] got=%h exp=%h", idx, out_states, exp); end
      checks++; if (out_last !== (idx == 7)) begin errors++; $display("FAIL stall_last[%0d] got=%b exp=%b", idx, out_last, (idx == 7)); end
      out_ready = 1'($urandom_range(0, 1));
      took = out_ready;
      $display("stall cyc %0d: chunk %0d states=%h ready=%b", cyc, idx, out_states[31:0], took);
      @(negedge clk);
      if (took) idx++;
    end
    checks++; if (idx != 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_bad_mode;
    logic [255:0] w;
    logic [255:0] exp;
    for (int j = 0; j < 32; j++) w[255-8*j -: 8] = 8'(j * 7 + 3);
    @(negedge clk);
    channels = 3'd6; out_ready = 1'b1; in_valid = 1'b1; in_data = ~w;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (err_mode !== 1'b1) begin errors++; $display("FAIL bad_err_mode got=%b exp=1", err_mode); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad_out_valid got=%b exp=0", out_valid); end
    $display("bad mode: err_mode=%b out_valid=%b", err_mode, out_valid);
    @(negedge clk);
    channels = 3'd1; in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp = {240'd0, w[255-16*c -: 16]};
      checks++; if (out_states !== exp) begin errors++; $display("FAIL m1_states[%0d] got=%h exp=%h", c, out_states, exp); end
      checks++; if (out_last !== (c == 15)) begin errors++; $display("FAIL m1_last[%0d] got=%b exp=%b", c, out_last, (c == 15)); end
      $display("mode1 chunk %0d: lanes1..0=%h last=%b", c, out_states[15:0], out_last);
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m1_drain got=%b exp=0", out_valid); end
    checks++; if (err_mode !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_mode); end
  endtask

  task automatic test_reset_midword;
    logic [255:0] w;
    for (int j = 0; j < 32; j++) w[255-8*j -: 8] = 8'(8'h40 + j);
    @(negedge clk);
    channels = 3'd0; out_ready = 1'b1; in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (out_states !== {248'd0, 8'h45}) begin errors++; $display("FAIL rstmid_pre got=%h exp=45", out_states[7:0]); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (out_states !== 256'd0) begin errors++; $display("FAIL rstmid_states got=%h exp=0", out_states); end
    checks++; if (err_mode !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", err_mode); end
    $display("reset mid-word: out_valid=%b err_mode=%b", out_valid, err_mode);
    @(negedge clk);
    rst = 1'b0;
    w[255:248] = 8'h5A;
    channels = 3'd0; in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_states !== {248'd0, 8'h5A}) begin errors++; $display("FAIL rstmid_first got=%h exp=5a", out_states[7:0]); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_first_last got=%b exp=0", out_last); end
    $display("after reset: first chunk lane0=%h", out_states[7:0]);
    repeat (32) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; channels = 3'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mode5_back_to_back();
    test_mode0();
    test_mode3();
    test_stall();
    test_bad_mode();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
